// File: rtl/tone_pkg.sv
// Shared constants for the tone divider selector: note table, table size and FSM state type.
// Counts are half-period values for a 50 MHz clock, Do up to Do'.
package tone_pkg;

    localparam int unsigned NUM_NOTES   = 8;
    localparam int unsigned IDX_W       = 3;
    localparam logic [31:0] RESET_COUNT = 32'h0000_BAB9;

    typedef enum logic [1:0] {
        S_MANUAL = 2'd0,
        S_AUTO   = 2'd1,
        S_MUTE   = 2'd2
    } state_e;

    function automatic logic [31:0] note_count(input logic [IDX_W-1:0] idx);
        logic [31:0] cnt;
        case (idx)
            3'd0:    cnt = 32'h0000_BAB9;
            3'd1:    cnt = 32'h0000_A65D;
            3'd2:    cnt = 32'h0000_9430;
            3'd3:    cnt = 32'h0000_8BE8;
            3'd4:    cnt = 32'h0000_7CB8;
            3'd5:    cnt = 32'h0000_6EF9;
            3'd6:    cnt = 32'h0000_62F1;
            default: cnt = 32'h0000_5D5C;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/tone_div_selector_if.sv
// Control inputs and divider outputs of the tone selector, bundled for the top-level port.
// The master side drives the raw buttons/levels; the slave side is the selector itself.
interface tone_div_selector_if;

    logic                         step_up;
    logic                         step_down;
    logic                         auto_en;
    logic                         mute;
    logic [31:0]                  div_clk_count;
    logic [tone_pkg::IDX_W-1:0]   note_idx;
    logic                         count_load;
    logic                         tone_en;

    modport master (
        output step_up,
        output step_down,
        output auto_en,
        output mute,
        input  div_clk_count,
        input  note_idx,
        input  count_load,
        input  tone_en
    );

    modport slave (
        input  step_up,
        input  step_down,
        input  auto_en,
        input  mute,
        output div_clk_count,
        output note_idx,
        output count_load,
        output tone_en
    );

endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a history flop; rise_o pulses once per rising edge of d_i.
// level_o is the synchronized level, usable on its own for slow level controls.
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], d_i};
        end
    end

    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/tone_div_selector.sv
// Selects the clock-divider half-period from a note table, stepped manually or auto-advanced,
// with a mute override. All outputs are registered.
module tone_div_selector #(
    parameter int unsigned NUM_NOTES   = tone_pkg::NUM_NOTES,
    parameter int unsigned AUTO_PERIOD = 50_000_000
) (
    input  logic                inclk,
    input  logic                Reset,
    tone_div_selector_if.slave  bus
);

    import tone_pkg::*;

    localparam logic [IDX_W-1:0] LastIdx   = IDX_W'(NUM_NOTES - 1);
    localparam logic [31:0]      DwellLast = 32'(AUTO_PERIOD - 1);

    logic up_rise;
    logic down_rise;
    logic up_lvl;
    logic down_lvl;
    logic auto_lvl;
    logic mute_lvl;
    logic unused_auto_rise;
    logic unused_mute_rise;
    logic unused_step_lvl;

    sync_edge_det u_sync_up (
        .clk_i   (inclk),
        .rst_ni  (Reset),
        .d_i     (bus.step_up),
        .level_o (up_lvl),
        .rise_o  (up_rise)
    );

    sync_edge_det u_sync_down (
        .clk_i   (inclk),
        .rst_ni  (Reset),
        .d_i     (bus.step_down),
        .level_o (down_lvl),
        .rise_o  (down_rise)
    );

    sync_edge_det u_sync_auto (
        .clk_i   (inclk),
        .rst_ni  (Reset),
        .d_i     (bus.auto_en),
        .level_o (auto_lvl),
        .rise_o  (unused_auto_rise)
    );

    sync_edge_det u_sync_mute (
        .clk_i   (inclk),
        .rst_ni  (Reset),
        .d_i     (bus.mute),
        .level_o (mute_lvl),
        .rise_o  (unused_mute_rise)
    );

    assign unused_step_lvl = up_lvl ^ down_lvl;

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        count_q;
    logic               count_load_q;
    logic               tone_en_q;
    logic [31:0]        dwell_q;

    logic [IDX_W-1:0]   idx_inc;
    logic [IDX_W-1:0]   idx_dec;
    logic [IDX_W-1:0]   idx_step;

    assign idx_inc  = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
    assign idx_dec  = (idx_q == '0) ? LastIdx : idx_q - 1'b1;
    assign idx_step = up_rise ? idx_inc : idx_dec;

    always_ff @(posedge inclk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= S_MANUAL;
            idx_q        <= '0;
            count_q      <= RESET_COUNT;
            count_load_q <= 1'b0;
            tone_en_q    <= 1'b1;
            dwell_q      <= 32'd0;
        end else begin
            count_load_q <= 1'b0;
            if (mute_lvl) begin
                // Mute overrides everything; index and count are frozen.
                state_q   <= S_MUTE;
                tone_en_q <= 1'b0;
            end else begin
                case (state_q)
                    S_MUTE: begin
                        state_q      <= auto_lvl ? S_AUTO : S_MANUAL;
                        tone_en_q    <= 1'b1;
                        count_load_q <= 1'b1;
                        dwell_q      <= 32'd0;
                    end
                    S_MANUAL: begin
                        if (auto_lvl) begin
                            state_q <= S_AUTO;
                            dwell_q <= 32'd0;
                        end else if (up_rise ^ down_rise) begin
                            idx_q        <= idx_step;
                            count_q      <= note_count(idx_step);
                            count_load_q <= 1'b1;
                        end
                    end
                    S_AUTO: begin
                        if (!auto_lvl) begin
                            state_q <= S_MANUAL;
                        end else if (dwell_q == DwellLast) begin
                            dwell_q      <= 32'd0;
                            idx_q        <= idx_inc;
                            count_q      <= note_count(idx_inc);
                            count_load_q <= 1'b1;
                        end else begin
                            dwell_q <= dwell_q + 32'd1;
                        end
                    end
                    default: begin
                        state_q <= S_MANUAL;
                    end
                endcase
            end
        end
    end

    assign bus.div_clk_count = count_q;
    assign bus.note_idx      = idx_q;
    assign bus.count_load    = count_load_q;
    assign bus.tone_en       = tone_en_q;

endmodule

// File: tb/tb_tone_div_selector.sv
// Scoreboarded bench: stimulus queues each expected count_load (cycle, index, count, tone_en);
// a negedge monitor pops and compares on every count_load strobe.
module tb_tone_div_selector;

    localparam logic [31:0] NOTE_TBL [8] = '{32'hBAB9, 32'hA65D, 32'h9430, 32'h8BE8,
                                             32'h7CB8, 32'h6EF9, 32'h62F1, 32'h5D5C};

    typedef struct {
        int          cyc;
        logic [2:0]  idx;
        logic [31:0] cnt;
        logic        tone;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tone_div_selector_if bus ();

    tone_div_selector #(
        .NUM_NOTES   (8),
        .AUTO_PERIOD (4)
    ) dut (
        .inclk (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int i, input logic t);
        exp_t e;
        e.cyc  = c;
        e.idx  = 3'(i);
        e.cnt  = NOTE_TBL[i];
        e.tone = t;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Called at a negedge; a detected step lands three cycle-counts later.
    task automatic pulse(input logic up, input logic dn, input logic exp_load, input int idx);
        bus.step_up   = up;
        bus.step_down = dn;
        if (exp_load) push(cyc + 3, idx, 1'b1);
        repeat (3) @(negedge clk);
        bus.step_up   = 1'b0;
        bus.step_down = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (bus.count_load === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_load: got idx %0d count 0x%0h, expected no strobe (cycle %0d)",
                         bus.note_idx, bus.div_clk_count, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("load_cycle", 32'(cyc), 32'(mon_e.cyc));
                check("load_idx", 32'(bus.note_idx), 32'(mon_e.idx));
                check("load_count", bus.div_clk_count, mon_e.cnt);
                check("load_tone", 32'(bus.tone_en), 32'(mon_e.tone));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int t0;
    int tm;
    int tr;

    initial begin
        bus.step_up   = 1'b0;
        bus.step_down = 1'b0;
        bus.auto_en   = 1'b0;
        bus.mute      = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_count", bus.div_clk_count, 32'hBAB9);
        check("reset_idx", 32'(bus.note_idx), 32'd0);
        check("reset_tone", 32'(bus.tone_en), 32'd1);
        check("reset_load", 32'(bus.count_load), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_idx", 32'(bus.note_idx), 32'd0);

        // Manual stepping including both wrap directions and a simultaneous press.
        pulse(1'b1, 1'b0, 1'b1, 1);
        pulse(1'b0, 1'b1, 1'b1, 0);
        pulse(1'b0, 1'b1, 1'b1, 7);
        pulse(1'b1, 1'b0, 1'b1, 0);
        pulse(1'b1, 1'b0, 1'b1, 1);
        pulse(1'b1, 1'b0, 1'b1, 2);
        pulse(1'b1, 1'b1, 1'b0, 0);
        check("simul_idx", 32'(bus.note_idx), 32'd2);
        check("simul_count", bus.div_clk_count, 32'h9430);
        check("manual_pending", 32'(exp_q.size()), 32'd0);

        // Auto mode: first advance four cycles after entry, then every four; steps ignored.
        t0 = cyc;
        bus.auto_en = 1'b1;
        for (int k = 0; k < 8; k++) push(t0 + 7 + 4 * k, (3 + k) % 8, 1'b1);
        wait_until(t0 + 5);
        bus.step_up = 1'b1;
        wait_until(t0 + 9);
        bus.step_up = 1'b0;
        wait_until(t0 + 13);
        bus.step_down = 1'b1;
        wait_until(t0 + 17);
        bus.step_down = 1'b0;
        wait_until(t0 + 21);
        bus.step_up   = 1'b1;
        bus.step_down = 1'b1;
        wait_until(t0 + 24);
        bus.step_up   = 1'b0;
        bus.step_down = 1'b0;
        wait_until(t0 + 36);
        check("auto_pending", 32'(exp_q.size()), 32'd0);

        // Mute lands exactly when the dwell would expire; mute must win.
        bus.mute = 1'b1;
        wait_until(t0 + 41);
        check("mute_tone", 32'(bus.tone_en), 32'd0);
        check("mute_idx", 32'(bus.note_idx), 32'd2);
        wait_until(t0 + 49);
        check("mute_hold_idx", 32'(bus.note_idx), 32'd2);
        check("mute_hold_count", bus.div_clk_count, 32'h9430);
        check("mute_hold_tone", 32'(bus.tone_en), 32'd0);
        tr = cyc;
        bus.mute = 1'b0;
        push(tr + 3, 2, 1'b1);
        push(tr + 7, 3, 1'b1);
        wait_until(tr + 4);
        check("unmute_tone", 32'(bus.tone_en), 32'd1);
        wait_until(tr + 7);
        bus.auto_en = 1'b0;
        wait_until(tr + 8);
        check("unmute_pending", 32'(exp_q.size()), 32'd0);
        wait_until(tr + 14);
        check("auto_exit_idx", 32'(bus.note_idx), 32'd3);

        pulse(1'b1, 1'b0, 1'b1, 4);

        // Mute from manual; a step pressed while muted is ignored.
        tm = cyc;
        bus.mute = 1'b1;
        wait_until(tm + 4);
        check("mute_manual_tone", 32'(bus.tone_en), 32'd0);
        pulse(1'b1, 1'b0, 1'b0, 0);
        check("mute_step_idx", 32'(bus.note_idx), 32'd4);
        tr = cyc;
        bus.mute = 1'b0;
        push(tr + 3, 4, 1'b1);
        wait_until(tr + 5);
        check("unmute_manual_tone", 32'(bus.tone_en), 32'd1);
        check("unmute_manual_pending", 32'(exp_q.size()), 32'd0);

        // Reset while a step is still in the synchronizer.
        bus.step_up = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset_idx", 32'(bus.note_idx), 32'd0);
        check("async_reset_count", bus.div_clk_count, 32'hBAB9);
        check("async_reset_tone", 32'(bus.tone_en), 32'd1);
        check("async_reset_load", 32'(bus.count_load), 32'd0);
        bus.step_up = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_reset_idx", 32'(bus.note_idx), 32'd0);
        pulse(1'b1, 1'b0, 1'b1, 1);
        repeat (2) @(negedge clk);
        check("final_pending", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
